// File: rtl/req_hold_initiator_if.sv
// Request/enable hold handshake bundle between a payload source, the
// initiator and its responder. The initiator uses the master modport.
interface req_hold_initiator_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  logic                       start;
  logic [DW-1:0]              din;
  logic                       en;
  logic                       a;
  logic [DW-1:0]              dout;
  logic                       done;
  logic                       busy;
  logic [$clog2(DEPTH+1)-1:0] pend;
  logic                       ovf;
  logic                       err;

  modport master (
    input  start, din, en,
    output a, dout, done, busy, pend, ovf, err
  );

  modport slave (
    output start, din, en,
    input  a, dout, done, busy, pend, ovf, err
  );
endinterface

// File: rtl/req_hold_initiator.sv
// Initiator side of the request/enable hold handshake.
// Payload words are queued in a DEPTH-entry FIFO; the head entry is presented
// on dout with a held high until en is sampled high. The entry stays counted
// in pend while it is in flight and is popped on acceptance.
// Optional feature: define REQ_TIMEOUT_EN to abort a request that has been
// held for TIMEOUT cycles without en (sets the sticky err flag).
module req_hold_initiator #(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int GAP_CYC = 1,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  req_hold_initiator_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  // Reject parameter sets the pointer arithmetic and counters cannot handle.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || GAP_CYC < 0 || TIMEOUT < 1) begin : g_bad_param
    $error("req_hold_initiator: illegal DEPTH/GAP_CYC/TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  state_t          state_q, state_d;
  logic            a_q, a_d;
  logic [DW-1:0]   dout_q, dout_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [DW-1:0]   mem [DEPTH];

  logic            full;
  logic            push;
  logic            pop;
  logic            release_req;

`ifdef REQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   to_q, to_d;
  logic            err_q, err_d;
`endif

  // Next-state, FIFO bookkeeping and output computation.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    dout_d      = dout_q;
    done_d      = 1'b0;
    gap_d       = gap_q;
    pop         = 1'b0;
    release_req = 1'b0;
    full        = (cnt_q == PW'(DEPTH));
    push        = bus.start & ~full;
    ovf_d       = ovf_q | (bus.start & full);
`ifdef REQ_TIMEOUT_EN
    to_d        = to_q;
    err_d       = err_q;
`endif

    case (state_q)
      IDLE: begin
        // A push into an empty FIFO is forwarded straight to dout so the
        // request rises one cycle after start.
        if (cnt_q != '0) begin
          a_d     = 1'b1;
          dout_d  = mem[rd_ptr_q];
          state_d = REQ;
`ifdef REQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end else if (push) begin
          a_d     = 1'b1;
          dout_d  = bus.din;
          state_d = REQ;
`ifdef REQ_TIMEOUT_EN
          to_d    = '0;
`endif
        end
      end
      REQ: begin
        if (bus.en) begin
          release_req = 1'b1;
          done_d      = 1'b1;
        end
`ifdef REQ_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT - 1)) begin
          release_req = 1'b1;
          err_d       = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
        if (release_req) begin
          a_d = 1'b0;
          pop = 1'b1;
          if (GAP_CYC > 0) begin
            state_d = GAP;
            gap_d   = GW'(GAP_CYC - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        a_d     = 1'b0;
      end
    endcase

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Control and output registers; reset overrides every other event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= 1'b0;
      dout_q   <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      gap_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      gap_q    <= gap_d;
    end
  end

  // Payload storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.din;
    end
  end

`ifdef REQ_TIMEOUT_EN
  // Hold-time counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_q  <= '0;
      err_q <= 1'b0;
    end else begin
      to_q  <= to_d;
      err_q <= err_d;
    end
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.a    = a_q;
  assign bus.dout = dout_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.pend = cnt_q;
  assign bus.busy = (cnt_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_req_hold_initiator.sv
// Testbench for req_hold_initiator: directed scenarios plus a randomized run
// checked against a timing-rule model (payload queue, low-time and hold-time
// counts) kept in the bench.
module tb_req_hold_initiator;

  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int GAP_CYC = 1;
  localparam int TIMEOUT = 16;
  localparam int PW      = $clog2(DEPTH + 1);

  logic clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  req_hold_initiator_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  req_hold_initiator #(
    .DW(DW), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [DW-1:0] mq[$];
  logic          m_a, m_done, m_ovf, m_err;
  logic [DW-1:0] m_dout;
  int            low_done;   // completed low cycles since the last fall
  int            held;       // cycles a has been high in the current request

  // Apply the handshake rules for one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic s, input logic [DW-1:0] d, input logic e);
    logic psh, pp;
    if (r) begin
      mq.delete();
      m_a = 0; m_dout = '0; m_done = 0; m_ovf = 0; m_err = 0;
      low_done = 1 + GAP_CYC; held = 0;
    end else begin
      psh = s && (mq.size() < DEPTH);
      if (s && mq.size() == DEPTH) m_ovf = 1;
      pp = 0;
      m_done = 0;
      if (m_a) begin
        if (e) begin
          m_a = 0; m_done = 1; pp = 1;
        end
`ifdef REQ_TIMEOUT_EN
        else if (held == TIMEOUT) begin
          m_a = 0; m_err = 1; pp = 1;
        end
`endif
        else held++;
        if (!m_a) low_done = 0;
      end else begin
        if (low_done + 1 >= 1 + GAP_CYC && (mq.size() > 0 || psh)) begin
          m_a = 1;
          m_dout = (mq.size() > 0) ? mq[0] : d;
          held = 1;
        end else if (low_done < 1 + GAP_CYC) begin
          low_done++;
        end
      end
      if (pp) void'(mq.pop_front());
      if (psh) mq.push_back(d);
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit later.
  task automatic step(input logic r, input logic s, input logic [DW-1:0] d, input logic e);
    rst = r; bus.start = s; bus.din = d; bus.en = e;
    @(posedge clk);
    model_edge(r, s, d, e);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 8'hFF, 1);
    step(1, 1, 8'hFF, 1);
    n_tests++; if (bus.a !== 1'b0) begin n_fail++; $display("FAIL reset_a: got %b expected 0", bus.a); end
    n_tests++; if (bus.dout !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", bus.dout); end
    n_tests++; if (bus.pend !== PW'(0)) begin n_fail++; $display("FAIL reset_pend: got %0d expected 0", bus.pend); end
    n_tests++; if ({bus.done, bus.busy, bus.ovf, bus.err} !== 4'b0000) begin n_fail++;
      $display("FAIL reset_flags: got done/busy/ovf/err=%b expected 0000", {bus.done, bus.busy, bus.ovf, bus.err}); end
  endtask

  task automatic test_single();
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 8'hA5, 0);
    n_tests++; if (bus.a !== 1'b1 || bus.dout !== 8'hA5 || bus.pend !== PW'(1)) begin n_fail++;
      $display("FAIL single_rise: got a=%b dout=%h pend=%0d expected a=1 dout=a5 pend=1", bus.a, bus.dout, bus.pend); end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      n_tests++; if (bus.a !== 1'b1 || bus.dout !== 8'hA5) begin n_fail++;
        $display("FAIL single_hold: cycle %0d got a=%b dout=%h expected a=1 dout=a5", i, bus.a, bus.dout); end
    end
    step(0, 0, 0, 1);
    n_tests++; if (bus.a !== 1'b0 || bus.done !== 1'b1 || bus.pend !== PW'(0)) begin n_fail++;
      $display("FAIL single_accept: got a=%b done=%b pend=%0d expected a=0 done=1 pend=0", bus.a, bus.done, bus.pend); end
    step(0, 0, 0, 0);
    n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got done=%b expected 0", bus.done); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words [3];
    logic [DW-1:0] rises[$];
    logic          prev_a;
    int            done_cnt, high_run, low_run;
    bit            seen_fall;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    prev_a = 0; done_cnt = 0; high_run = 0; low_run = 0; seen_fall = 0;
    for (int i = 0; i < 14; i++) begin
      if (i < 3) step(0, 1, words[i], 1);
      else       step(0, 0, 8'h00, 1);
      if (bus.done === 1'b1) done_cnt++;
      if (bus.a === 1'b1) begin
        if (!prev_a) begin
          rises.push_back(bus.dout);
          if (seen_fall) begin
            n_tests++; if (low_run != 1 + GAP_CYC) begin n_fail++;
              $display("FAIL b2b_low_time: got %0d expected %0d", low_run, 1 + GAP_CYC); end
          end
          high_run = 0;
        end
        high_run++;
      end else begin
        if (prev_a) begin
          n_tests++; if (high_run != 1) begin n_fail++;
            $display("FAIL b2b_high_time: got %0d expected 1", high_run); end
          seen_fall = 1; low_run = 0;
        end
        low_run++;
      end
      prev_a = bus.a;
    end
    n_tests++; if (rises.size() != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", rises.size()); end
    for (int i = 0; i < 3 && i < rises.size(); i++) begin
      n_tests++; if (rises[i] !== words[i]) begin n_fail++;
        $display("FAIL b2b_dout[%0d]: got %h expected %h", i, rises[i], words[i]); end
    end
    n_tests++; if (done_cnt != 3) begin n_fail++; $display("FAIL b2b_done: got %0d expected 3", done_cnt); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] seen[$];
    logic          prev_a;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'h41 + DW'(i), 0);
    n_tests++; if (bus.pend !== PW'(4) || bus.ovf !== 1'b1) begin n_fail++;
      $display("FAIL ovf_full: got pend=%0d ovf=%b expected pend=4 ovf=1", bus.pend, bus.ovf); end
    seen.push_back(bus.dout);
    prev_a = bus.a;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1);
      if (bus.a === 1'b1 && !prev_a) seen.push_back(bus.dout);
      prev_a = bus.a;
    end
    n_tests++; if (seen.size() != 4) begin n_fail++; $display("FAIL ovf_drain_count: got %0d expected 4", seen.size()); end
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      n_tests++; if (seen[i] !== 8'h41 + DW'(i)) begin n_fail++;
        $display("FAIL ovf_drain[%0d]: got %h expected %h", i, seen[i], 8'h41 + DW'(i)); end
    end
    n_tests++; if (bus.pend !== PW'(0) || bus.ovf !== 1'b1) begin n_fail++;
      $display("FAIL ovf_after: got pend=%0d ovf=%b expected pend=0 ovf=1", bus.pend, bus.ovf); end
  endtask

  task automatic test_push_pop();
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 8'h01, 0);
    step(0, 1, 8'h02, 0);
    n_tests++; if (bus.pend !== PW'(2) || bus.a !== 1'b1) begin n_fail++;
      $display("FAIL pp_setup: got pend=%0d a=%b expected pend=2 a=1", bus.pend, bus.a); end
    step(0, 1, 8'h03, 1);
    n_tests++; if (bus.pend !== PW'(2) || bus.done !== 1'b1) begin n_fail++;
      $display("FAIL pp_same_edge: got pend=%0d done=%b expected pend=2 done=1", bus.pend, bus.done); end
  endtask

  task automatic test_reset_mid();
    int rises;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 8'h77, 0);
    step(0, 1, 8'h78, 0);
    step(1, 0, 0, 0);
    n_tests++; if (bus.a !== 1'b0 || bus.pend !== PW'(0) || bus.busy !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid: got a=%b pend=%0d busy=%b expected a=0 pend=0 busy=0", bus.a, bus.pend, bus.busy); end
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      if (bus.a !== 1'b0) rises++;
    end
    n_tests++; if (rises != 0) begin n_fail++; $display("FAIL rst_mid_quiet: got %0d high cycles expected 0", rises); end
  endtask

`ifdef REQ_TIMEOUT_EN
  task automatic test_timeout();
    int high; bit done_seen;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 8'h5A, 0);
    high = (bus.a === 1'b1) ? 1 : 0; done_seen = 0;
    for (int i = 0; i < 40 && bus.a === 1'b1; i++) begin
      step(0, 0, 0, 0);
      if (bus.a === 1'b1) high++;
      if (bus.done === 1'b1) done_seen = 1;
    end
    n_tests++; if (high != TIMEOUT) begin n_fail++; $display("FAIL timeout_len: got %0d expected %0d", high, TIMEOUT); end
    n_tests++; if (bus.err !== 1'b1 || done_seen) begin n_fail++;
      $display("FAIL timeout_flags: got err=%b done_seen=%0d expected err=1 done_seen=0", bus.err, done_seen); end
  endtask
`endif

  task automatic test_random();
    logic r, s, e;
    logic [DW-1:0] d;
    step(1, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 79) == 0);
      s = ($urandom_range(0, 99) < 45);
      e = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 30 : 70));
      d = DW'($urandom);
      step(r, s, d, e);
      n_tests++; if (bus.a !== m_a) begin n_fail++; $display("FAIL rnd_a: cycle %0d got %b expected %b", i, bus.a, m_a); end
      n_tests++; if (bus.dout !== m_dout) begin n_fail++; $display("FAIL rnd_dout: cycle %0d got %h expected %h", i, bus.dout, m_dout); end
      n_tests++; if (bus.done !== m_done) begin n_fail++; $display("FAIL rnd_done: cycle %0d got %b expected %b", i, bus.done, m_done); end
      n_tests++; if (bus.pend !== PW'(mq.size())) begin n_fail++; $display("FAIL rnd_pend: cycle %0d got %0d expected %0d", i, bus.pend, mq.size()); end
      n_tests++; if (bus.busy !== (mq.size() != 0 || m_a || low_done < GAP_CYC)) begin n_fail++;
        $display("FAIL rnd_busy: cycle %0d got %b expected %b", i, bus.busy, (mq.size() != 0 || m_a || low_done < GAP_CYC)); end
      n_tests++; if (bus.ovf !== m_ovf) begin n_fail++; $display("FAIL rnd_ovf: cycle %0d got %b expected %b", i, bus.ovf, m_ovf); end
      n_tests++; if (bus.err !== m_err) begin n_fail++; $display("FAIL rnd_err: cycle %0d got %b expected %b", i, bus.err, m_err); end
      $display("[TB] cyc %0d rst=%b start=%b din=%h en=%b -> a=%b dout=%h done=%b pend=%0d", i, r, s, d, e, bus.a, bus.dout, bus.done, bus.pend);
    end
  endtask

  // Absolute bound on simulation time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.din = '0; bus.en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_push_pop();
    test_reset_mid();
`ifdef REQ_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
